disp_scan_ctrl: RTL and testbench

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

---
 rtl/disp_pkg.sv | 15 +
 rtl/disp_scan_ctrl_if.sv | 19 +
 rtl/decode2.sv | 10 +
 rtl/decode7.sv | 16 +
 rtl/disp_phase_timer.sv | 24 ++
 rtl/disp_scan_ctrl.sv | 82 ++++++++
 tb/tb_disp_scan_ctrl.sv | 149 ++++++++++++++
 7 files changed

// File: rtl/disp_pkg.sv
// Shared types and sizes for the four-digit display scan controller.
package disp_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 2;
  localparam int NIBBLE_W   = 4;

  typedef enum logic {ST_BLANK = 1'b0, ST_ON = 1'b1} disp_state_e;

  // Phase counter width able to hold max(a, b) distinct counts.
  function automatic int phase_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Update handshake, digit enables and scan outputs of the display controller.
interface disp_scan_ctrl_if;
  import disp_pkg::*;
  logic                             upd_req;
  logic [NUM_DIGITS*NIBBLE_W-1:0]   upd_data;
  logic                             upd_ack;
  logic [NUM_DIGITS-1:0]            digit_en;
  logic [DIGIT_W-1:0]               digit;
  logic [NIBBLE_W-1:0]              disp_digit;
  logic                             blank;
  logic                             frame_start;
  logic [NUM_DIGITS-1:0]            dig_sel;
  logic [6:0]                       seg;

  modport master (output upd_req, upd_data, digit_en,
                  input  upd_ack, digit, disp_digit, blank, frame_start, dig_sel, seg);
  modport slave  (input  upd_req, upd_data, digit_en,
                  output upd_ack, digit, disp_digit, blank, frame_start, dig_sel, seg);
endinterface

// File: rtl/decode2.sv
// Two-bit digit index to one-hot digit select.
module decode2 (
  input  logic [1:0] sel_i,
  output logic [3:0] onehot_o
);
  always_comb begin
    onehot_o        = '0;
    onehot_o[sel_i] = 1'b1;
  end
endmodule

// File: rtl/decode7.sv
// Hex nibble to seven-segment pattern, bit order {g,f,e,d,c,b,a}, active high.
module decode7 (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'h00;
    case (nib_i)
      4'h0: seg_o = 7'h3F;  4'h1: seg_o = 7'h06;  4'h2: seg_o = 7'h5B;  4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;  4'h5: seg_o = 7'h6D;  4'h6: seg_o = 7'h7D;  4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;  4'h9: seg_o = 7'h6F;  4'hA: seg_o = 7'h77;  4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;  4'hD: seg_o = 7'h5E;  4'hE: seg_o = 7'h79;  4'hF: seg_o = 7'h71;
      default: seg_o = 7'h00;
    endcase
  end
endmodule

// File: rtl/disp_phase_timer.sv
// Loadable down-counter; tc_o flags the cycle the count equals term_i.
module disp_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = load_i ? load_val_i : cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == term_i);
endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 4-digit display scanner: BLANK/ON slots per digit, frame-aligned
// double-buffered value update so a frame never shows a torn value.
module disp_scan_ctrl import disp_pkg::*; #(
  parameter int ON_CYCLES    = 12288,
  parameter int BLANK_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset,
  disp_scan_ctrl_if.slave  bus
);
  localparam int CW = phase_w(ON_CYCLES, BLANK_CYCLES);
  // The counter restarts at 0 and counts down, so after k cycles it reads -k.
  localparam logic [CW-1:0] ON_TERM    = CW'(-(ON_CYCLES - 1));
  localparam logic [CW-1:0] BLANK_TERM = CW'(-(BLANK_CYCLES - 1));

  disp_state_e                     state_q, state_d;
  logic [DIGIT_W-1:0]              idx_q, idx_d;
  logic [NUM_DIGITS*NIBBLE_W-1:0]  active_q, active_d;
  logic                            ack_q, ack_d, fs_q, fs_d;
  logic                            tc;
  logic [CW-1:0]                   term;

  assign term = (state_q == ST_ON) ? ON_TERM : BLANK_TERM;

  disp_phase_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst        (reset),
    .load_i     (tc),
    .load_val_i ('0),
    .term_i     (term),
    .tc_o       (tc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    active_d = active_q;
    ack_d    = 1'b0;
    fs_d     = 1'b0;
    if (tc) begin
      if (state_q == ST_BLANK) begin
        state_d = ST_ON;
      end else begin
        state_d = ST_BLANK;
        idx_d   = idx_q + 1'b1;
        // Leaving ON(3) is the frame boundary: the only point the value may change.
        if (idx_q == DIGIT_W'(NUM_DIGITS - 1)) begin
          fs_d = 1'b1;
          if (bus.upd_req) begin
            active_d = bus.upd_data;
            ack_d    = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_BLANK;
      idx_q    <= '0;
      active_q <= '0;
      ack_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      active_q <= active_d;
      ack_q    <= ack_d;
      fs_q     <= fs_d;
    end
  end

  assign bus.digit       = idx_q;
  assign bus.disp_digit  = active_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign bus.blank       = (state_q == ST_BLANK) | ~bus.digit_en[idx_q];
  assign bus.upd_ack     = ack_q;
  assign bus.frame_start = fs_q;

  decode2 u_dec2 (.sel_i(idx_q),          .onehot_o(bus.dig_sel));
  decode7 u_dec7 (.nib_i(bus.disp_digit), .seg_o(bus.seg));
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl with ON_CYCLES=4, BLANK_CYCLES=2 (6-cycle slot, 24-cycle frame).
module tb_disp_scan_ctrl;
  localparam int ONC = 4, BLC = 2, SLOT = ONC + BLC, FRAME = 4 * SLOT;

  logic clk = 1'b0, reset;
  always #5 clk = ~clk;

  disp_scan_ctrl_if bus ();
  disp_scan_ctrl #(.ON_CYCLES(ONC), .BLANK_CYCLES(BLC)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0, n_pass = 0;
  int t, acks, last_ack_t, ack_gap;
  logic [15:0] m_act;
  logic        m_pend;
  logic [6:0]  segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {int cyc; logic [3:0] en; int digit; int blank; int fs;} vec_t;
  vec_t vecs [17];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s t=%0d: got %0h want %0h", name, t, act, exp);
  endtask

  // Reference: position in the frame follows from the cycle count since reset.
  task automatic model_check(input logic [3:0] en);
    int dg, pos;
    logic on, fs;
    logic [3:0] nib;
    pos = t % FRAME;
    dg  = pos / SLOT;
    on  = (pos % SLOT) >= BLC;
    fs  = (pos == 0) && (t > 0);
    nib = m_act[dg*4 +: 4];
    chk("digit",       bus.digit, dg);
    chk("blank",       bus.blank, (!on || !en[dg]) ? 1 : 0);
    chk("disp_digit",  bus.disp_digit, nib);
    chk("seg",         bus.seg, segtab[nib]);
    chk("dig_sel",     bus.dig_sel, 1 << dg);
    chk("frame_start", bus.frame_start, fs);
    chk("upd_ack",     bus.upd_ack, (fs && m_pend) ? 1 : 0);
  endtask

  // Drive one cycle (at posedge+1), check, advance the model; returns at next posedge+1.
  task automatic cyc(input logic req, input logic [15:0] data, input logic [3:0] en);
    bus.upd_req = req; bus.upd_data = data; bus.digit_en = en;
    #1;
    model_check(en);
    if (bus.upd_ack) begin
      if (acks > 0) ack_gap = t - last_ack_t;
      last_ack_t = t;
      acks++;
    end
    m_pend = ((t % FRAME) == FRAME - 1) && req;
    if (m_pend) m_act = data;
    t++;
    @(posedge clk); #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    t = 0; m_act = '0; m_pend = 1'b0; acks = 0; ack_gap = 0; last_ack_t = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.upd_req = 1'b0; bus.upd_data = '0; bus.digit_en = 4'hF;
    release_reset();
  endtask

  initial begin
    logic req, req_prev;
    logic [15:0] rdata;
    reset = 1'b1;
    bus.upd_req = 1'b0; bus.upd_data = '0; bus.digit_en = 4'hF;
    t = 0; acks = 0; ack_gap = 0; last_ack_t = 0;

    vecs = '{'{0, 4'hF, 0, 1, 0}, '{1, 4'hF, 0, 1, 0}, '{2, 4'hF, 0, 0, 0}, '{5, 4'hF, 0, 0, 0},
             '{6, 4'hF, 1, 1, 0}, '{8, 4'hF, 1, 0, 0}, '{14, 4'hF, 2, 0, 0}, '{20, 4'hF, 3, 0, 0},
             '{23, 4'hF, 3, 0, 0}, '{24, 4'hF, 0, 1, 1}, '{25, 4'hF, 0, 1, 0},
             '{2, 4'hA, 0, 1, 0}, '{5, 4'hA, 0, 1, 0}, '{8, 4'hA, 1, 0, 0},
             '{14, 4'hA, 2, 1, 0}, '{20, 4'hA, 3, 0, 0}, '{26, 4'hA, 0, 1, 0}};

    // Slot timing table from a fresh reset.
    foreach (vecs[i]) begin
      do_reset();
      repeat (vecs[i].cyc) cyc(1'b0, 16'h0, vecs[i].en);
      bus.digit_en = vecs[i].en;
      #1;
      chk("tbl_digit", bus.digit, vecs[i].digit);
      chk("tbl_blank", bus.blank, vecs[i].blank);
      chk("tbl_fs",    bus.frame_start, vecs[i].fs);
      @(posedge clk); #1;
    end

    // Request raised during ON(1): held off until the boundary, single ack.
    do_reset();
    for (int i = 0; i < 8; i++)  cyc(1'b0, 16'h0, 4'hF);
    for (int i = 8; i < 24; i++) cyc(1'b1, 16'h12AB, 4'hF);
    for (int i = 24; i < 38; i++) cyc(1'b0, 16'h12AB, 4'hF);
    chk("one_ack", acks, 1);

    // Reset mid ON(2) with a request pending: immediate, no ack.
    bus.upd_req = 1'b1; bus.upd_data = 16'h5555;
    reset = 1'b1;
    #1;
    chk("rst_digit", bus.digit, 0);
    chk("rst_blank", bus.blank, 1);
    chk("rst_ack",   bus.upd_ack, 0);
    chk("rst_disp",  bus.disp_digit, 0);
    chk("rst_fs",    bus.frame_start, 0);
    @(posedge clk); #1;
    chk("rst_ack_hold", bus.upd_ack, 0);
    release_reset();
    for (int i = 0; i < 30; i++) cyc(1'b0, 16'h0, 4'hF);
    chk("no_ack_after_rst", acks, 0);

    // Request held across two boundaries with data changed between them.
    do_reset();
    for (int i = 0; i < 24; i++)  cyc(1'b1, 16'h12AB, 4'hF);
    for (int i = 24; i < 48; i++) cyc(1'b1, 16'h00FF, 4'hF);
    for (int i = 48; i < 72; i++) cyc(1'b0, 16'h0, 4'hF);
    chk("two_acks", acks, 2);
    chk("ack_gap", ack_gap, FRAME);

    // Request rising on the last cycle of ON(3).
    do_reset();
    for (int i = 0; i < 23; i++) cyc(1'b0, 16'h0, 4'hF);
    cyc(1'b1, 16'hBEEF, 4'hF);
    for (int i = 24; i < 48; i++) cyc(1'b0, 16'h0, 4'hF);
    chk("late_req_ack", acks, 1);

    // Random requests, data and enables.
    do_reset();
    req_prev = 1'b0; rdata = '0;
    for (int i = 0; i < 10 * FRAME; i++) begin
      if (!req_prev) rdata = 16'($urandom);
      req = ($urandom_range(0, 9) == 0) || (((t % FRAME) == FRAME - 1) && ($urandom_range(0, 1) == 1));
      cyc(req, rdata, 4'($urandom));
      req_prev = req;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
